c4_turn_ctrl: RTL

Turn sequencer for the 16x16 Connect Four display. It owns the column cursor, converts it to the one-hot `placement` / `left` / `right` encoding the board datapath consumes, and tracks per-column fill height so full columns are rejected. It also serialises drops so a new piece cannot launch while one is falling, alternates players, and ends the game on a win (from the external win detector) or a full board.

---
 rtl/c4_pkg.sv | 20 ++
 rtl/c4_col_heights.sv | 29 ++
 rtl/c4_turn_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/c4_pkg.sv
// Shared types and constants for the Connect Four turn sequencer.
// col_to_placement maps a cursor column onto the board's half-column one-hot code.
package c4_pkg;

    typedef enum logic [1:0] {SELECT, DROP, SETTLE, OVER} state_t;

    localparam int NUM_COLS = 16;
    localparam int ROWS     = 16;
    localparam int CELLS    = 256;

    // Returns {placement[7:0], is_left}; the left half counts down from column 8.
    function automatic logic [8:0] col_to_placement(input logic [3:0] col);
        logic [2:0] idx;
        logic [7:0] p;
        idx = col[3] ? ~col[2:0] : col[2:0];
        p   = 8'b1 << idx;
        return {p, col[3]};
    endfunction

endpackage

// File: rtl/c4_col_heights.sv
// Per-column fill heights (saturating at ROWS) and the total piece count.
module c4_col_heights
    import c4_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc_en,
    input  logic [3:0]          col,
    output logic [NUM_COLS-1:0] full,
    output logic [8:0]          count
);

    logic [NUM_COLS-1:0][4:0] height;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            height <= '0;
            count  <= '0;
        end else if (inc_en && !full[col]) begin
            height[col] <= height[col] + 5'd1;
            count       <= count + 9'd1;
        end
    end

    for (genvar i = 0; i < NUM_COLS; i++) begin : g_full
        assign full[i] = (height[i] == 5'(ROWS));
    end

endmodule

// File: rtl/c4_turn_ctrl.sv
// Turn sequencer: cursor, drop serialisation, player alternation and end-of-game.
// All outputs are registered from the next-state values computed below.
module c4_turn_ctrl
    import c4_pkg::*;
#(
    parameter int DROP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       cur_inc,
    input  logic       cur_dec,
    input  logic       drop_req,
    input  logic       win,
    output logic [7:0] placement,
    output logic       right,
    output logic       left,
    output logic       player,
    output logic [3:0] cursor,
    output logic       busy,
    output logic       reject,
    output logic       game_over,
    output logic       winner,
    output logic       draw
);

    localparam int TW = (DROP_CYCLES > 1) ? $clog2(DROP_CYCLES) : 1;

    state_t         state, state_d;
    logic [TW-1:0]  timer, timer_d;
    logic [3:0]     cursor_d;
    logic           player_d, winner_d, draw_d, over_d, reject_d, busy_d;
    logic           left_d, right_d, inc_en;
    logic [8:0]     pl_cur, pl_next;
    logic [NUM_COLS-1:0] full;
    logic [8:0]     count;

    c4_col_heights u_heights (
        .clk    (clk),
        .rst_n  (RST),
        .inc_en (inc_en),
        .col    (cursor),
        .full   (full),
        .count  (count)
    );

    always_comb begin
        state_d  = state;
        timer_d  = timer;
        cursor_d = cursor;
        player_d = player;
        winner_d = winner;
        draw_d   = draw;
        over_d   = game_over;
        reject_d = 1'b0;
        left_d   = 1'b0;
        right_d  = 1'b0;
        inc_en   = 1'b0;
        pl_cur   = col_to_placement(cursor);
        unique case (state)
            SELECT: begin
                // A drop wins over a same-cycle move and uses the current cursor.
                if (drop_req) begin
                    if (full[cursor]) begin
                        reject_d = 1'b1;
                    end else begin
                        inc_en  = 1'b1;
                        state_d = DROP;
                        timer_d = '0;
                        left_d  = pl_cur[0];
                        right_d = ~pl_cur[0];
                    end
                end else if (cur_inc && !cur_dec) begin
                    cursor_d = cursor + 4'd1;
                end else if (cur_dec && !cur_inc) begin
                    cursor_d = cursor - 4'd1;
                end
            end
            DROP: begin
                if (timer == TW'(DROP_CYCLES - 1)) state_d = SETTLE;
                else                               timer_d = timer + 1'b1;
            end
            SETTLE: begin
                if (win) begin
                    state_d  = OVER;
                    over_d   = 1'b1;
                    winner_d = player;
                end else if (count == 9'(CELLS)) begin
                    state_d = OVER;
                    over_d  = 1'b1;
                    draw_d  = 1'b1;
                end else begin
                    player_d = ~player;
                    state_d  = SELECT;
                end
            end
            OVER: ;
            default: state_d = SELECT;
        endcase
        busy_d  = (state_d == DROP) || (state_d == SETTLE);
        pl_next = col_to_placement(cursor_d);
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            state     <= SELECT;
            timer     <= '0;
            cursor    <= 4'd0;
            placement <= 8'b0000_0001;
            left      <= 1'b0;
            right     <= 1'b0;
            player    <= 1'b0;
            busy      <= 1'b0;
            reject    <= 1'b0;
            game_over <= 1'b0;
            winner    <= 1'b0;
            draw      <= 1'b0;
        end else begin
            state     <= state_d;
            timer     <= timer_d;
            cursor    <= cursor_d;
            placement <= pl_next[8:1];
            left      <= left_d;
            right     <= right_d;
            player    <= player_d;
            busy      <= busy_d;
            reject    <= reject_d;
            game_over <= over_d;
            winner    <= winner_d;
            draw      <= draw_d;
        end
    end

endmodule
